// File: rtl/nic_output_port_lookup_mp.sv
// Multi-port NIC output port lookup: rewrites the tuser destination field per packet.
// Optional idle-byte counters are enabled with `define NIC_OPL_IDLE_BYTES_EN.
module nic_output_port_lookup_mp #(
    parameter int unsigned DATA_WIDTH      = 512,
    parameter int unsigned TUSER_WIDTH     = 128,
    parameter int unsigned NUM_PORTS       = 4,
    parameter int unsigned SRC_PORT_POS    = 16,
    parameter int unsigned DST_PORT_POS    = 24,
    parameter int unsigned FIFO_DEPTH_BITS = 2,
    parameter int unsigned CNT_WIDTH       = 32,
    parameter int unsigned DEFAULT_DST     = 1
) (
    input  logic                    axis_aclk,
    input  logic                    axis_reset,
    input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
    input  logic [DATA_WIDTH/8-1:0] s_axis_tkeep,
    input  logic [TUSER_WIDTH-1:0]  s_axis_tuser,
    input  logic                    s_axis_tvalid,
    input  logic                    s_axis_tlast,
    output logic                    s_axis_tready,
    output logic [DATA_WIDTH-1:0]   m_axis_tdata,
    output logic [DATA_WIDTH/8-1:0] m_axis_tkeep,
    output logic [TUSER_WIDTH-1:0]  m_axis_tuser,
    output logic                    m_axis_tvalid,
    output logic                    m_axis_tlast,
    input  logic                    m_axis_tready,
    input  logic [1:0]              mode,
    input  logic                    cnt_clear,
`ifdef NIC_OPL_IDLE_BYTES_EN
    output logic [CNT_WIDTH-1:0]    idle_in_cnt,
    output logic [CNT_WIDTH-1:0]    idle_out_cnt,
`endif
    output logic [CNT_WIDTH-1:0]    pkt_in_cnt,
    output logic [CNT_WIDTH-1:0]    pkt_out_cnt,
    output logic [CNT_WIDTH-1:0]    pkt_drop_cnt
);
    localparam int unsigned PW    = 2 * NUM_PORTS;
    localparam int unsigned KW    = DATA_WIDTH / 8;
    localparam int unsigned DEPTH = 2 ** FIFO_DEPTH_BITS;
    localparam int unsigned PTRW  = FIFO_DEPTH_BITS;
    localparam int unsigned OCCW  = FIFO_DEPTH_BITS + 1;
    localparam int unsigned FW    = DATA_WIDTH + KW + TUSER_WIDTH + 1;
    localparam int unsigned CW    = CNT_WIDTH - 1;
    localparam int unsigned AW    = $clog2(KW + 1);
    localparam int unsigned SW    = ((CW > AW) ? CW : AW) + 1;

    typedef enum logic [1:0] {S_HEADER, S_FORWARD, S_DROP} state_t;

    logic [FW-1:0]          r_mem [DEPTH];
    logic [PTRW-1:0]        r_wr_ptr, r_rd_ptr;
    logic [OCCW-1:0]        r_count;
    state_t                 r_state, w_state_nxt;
    logic                   r_hold;
    logic [PW-1:0]          r_dst;
    logic [CNT_WIDTH-1:0]   r_in_cnt, r_out_cnt, r_drop_cnt;

    logic                   w_empty, w_wr, w_rd, w_tvalid, w_drop_pkt;
    logic                   w_h_last;
    logic [TUSER_WIDTH-1:0] w_h_user, w_out_user;
    logic [KW-1:0]          w_h_keep;
    logic [DATA_WIDTH-1:0]  w_h_data;
    logic [PW-1:0]          w_src, w_calc_dst, w_dst;
    logic                   w_calc_drop, w_in_last, w_out_last;

    // Saturating add; any sum beyond the count range sets the sticky MSB.
    function automatic logic [CNT_WIDTH-1:0] f_sat(input logic [CNT_WIDTH-1:0] c,
                                                   input logic [AW-1:0] amt);
        logic [SW-1:0] sum;
        sum = SW'(c[CW-1:0]) + SW'(amt);
        if (sum > SW'({CW{1'b1}})) f_sat = {1'b1, {CW{1'b1}}};
        else                       f_sat = {c[CW], sum[CW-1:0]};
    endfunction

    assign w_empty       = (r_count == '0);
    assign s_axis_tready = (r_count < OCCW'(DEPTH - 1));
    assign w_wr          = s_axis_tvalid & s_axis_tready;
    assign {w_h_last, w_h_user, w_h_keep, w_h_data} = r_mem[r_rd_ptr];

    always_ff @(posedge axis_aclk) begin
        if (w_wr) r_mem[r_wr_ptr] <= {s_axis_tlast, s_axis_tuser, s_axis_tkeep, s_axis_tdata};
    end

    always_ff @(posedge axis_aclk) begin
        if (axis_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + PTRW'(1);
            if (w_rd) r_rd_ptr <= r_rd_ptr + PTRW'(1);
            if (w_wr && !w_rd)      r_count <= r_count + OCCW'(1);
            else if (!w_wr && w_rd) r_count <= r_count - OCCW'(1);
        end
    end

    // Destination / drop decision for the beat at the FIFO head.
    always_comb begin
        w_src       = w_h_user[SRC_PORT_POS +: PW];
        w_calc_dst  = '0;
        w_calc_drop = 1'b0;
        if (w_src == '0) begin
            w_calc_dst = PW'(DEFAULT_DST);
        end else if ((w_src & (w_src - PW'(1))) != '0) begin
            w_calc_drop = 1'b1;
        end else if (mode == 2'd2) begin
            w_calc_drop = 1'b1;
        end else if (mode == 2'd1) begin
            w_calc_dst = w_src;
        end else begin
            for (int i = 0; i < int'(NUM_PORTS); i++) begin
                w_calc_dst[2*i]   = w_src[2*i+1];
                w_calc_dst[2*i+1] = w_src[2*i];
            end
        end
    end

    // r_hold freezes the decision while a header beat is stalled downstream.
    always_comb begin
        w_state_nxt = r_state;
        w_tvalid    = 1'b0;
        w_rd        = 1'b0;
        w_drop_pkt  = 1'b0;
        w_dst       = r_dst;
        case (r_state)
            S_HEADER: begin
                if (!r_hold) w_dst = w_calc_dst;
                if (!w_empty) begin
                    if (w_calc_drop && !r_hold) begin
                        w_rd = 1'b1;
                        if (w_h_last) w_drop_pkt  = 1'b1;
                        else          w_state_nxt = S_DROP;
                    end else begin
                        w_tvalid = 1'b1;
                        w_rd     = m_axis_tready;
                        if (m_axis_tready && !w_h_last) w_state_nxt = S_FORWARD;
                    end
                end
            end
            S_FORWARD: begin
                w_tvalid = !w_empty;
                w_rd     = !w_empty && m_axis_tready;
                if (w_rd && w_h_last) w_state_nxt = S_HEADER;
            end
            S_DROP: begin
                w_rd = !w_empty;
                if (!w_empty && w_h_last) begin
                    w_drop_pkt  = 1'b1;
                    w_state_nxt = S_HEADER;
                end
            end
            default: w_state_nxt = S_HEADER;
        endcase
    end

    always_ff @(posedge axis_aclk) begin
        if (axis_reset) begin
            r_state <= S_HEADER;
            r_hold  <= 1'b0;
            r_dst   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_hold  <= (r_state == S_HEADER) && !w_empty && !w_rd;
            if (r_state == S_HEADER) r_dst <= w_dst;
        end
    end

    always_comb begin
        w_out_user                      = w_h_user;
        w_out_user[DST_PORT_POS +: PW]  = w_dst;
    end

    assign m_axis_tvalid = w_tvalid;
    assign m_axis_tdata  = w_h_data;
    assign m_axis_tkeep  = w_h_keep;
    assign m_axis_tuser  = w_out_user;
    assign m_axis_tlast  = w_h_last;

    assign w_in_last  = w_wr & s_axis_tlast;
    assign w_out_last = w_tvalid & m_axis_tready & w_h_last;

    always_ff @(posedge axis_aclk) begin
        if (axis_reset || cnt_clear) begin
            r_in_cnt   <= '0;
            r_out_cnt  <= '0;
            r_drop_cnt <= '0;
        end else begin
            r_in_cnt   <= f_sat(r_in_cnt,   AW'(w_in_last));
            r_out_cnt  <= f_sat(r_out_cnt,  AW'(w_out_last));
            r_drop_cnt <= f_sat(r_drop_cnt, AW'(w_drop_pkt));
        end
    end

    assign pkt_in_cnt   = r_in_cnt;
    assign pkt_out_cnt  = r_out_cnt;
    assign pkt_drop_cnt = r_drop_cnt;

`ifdef NIC_OPL_IDLE_BYTES_EN
    logic [AW-1:0]        w_in_zeros, w_out_zeros;
    logic [CNT_WIDTH-1:0] r_idle_in, r_idle_out;

    // Unused byte lanes on the closing beat of each packet.
    always_comb begin
        w_in_zeros  = '0;
        w_out_zeros = '0;
        for (int i = 0; i < int'(KW); i++) begin
            w_in_zeros  = w_in_zeros  + AW'(~s_axis_tkeep[i]);
            w_out_zeros = w_out_zeros + AW'(~w_h_keep[i]);
        end
    end

    always_ff @(posedge axis_aclk) begin
        if (axis_reset || cnt_clear) begin
            r_idle_in  <= '0;
            r_idle_out <= '0;
        end else begin
            r_idle_in  <= f_sat(r_idle_in,  w_in_last  ? w_in_zeros  : '0);
            r_idle_out <= f_sat(r_idle_out, w_out_last ? w_out_zeros : '0);
        end
    end

    assign idle_in_cnt  = r_idle_in;
    assign idle_out_cnt = r_idle_out;
`endif

endmodule

// File: doc/nic_output_port_lookup_mp.md
Name: nic_output_port_lookup_mp

Overview:
Parametrised multi-port successor to the NIC output port lookup. Sits between the RX input arbiter and the output queues and rewrites the tuser destination field per packet.
- Forwarding: MAC↔CPU pairing, with loopback and drop modes.
- Malformed source fields are dropped.
- Saturating in/out/drop statistics counters with sticky overflow flags.
- No AXI-Lite; counters are exported for a separate register wrapper.

Parameters:
DATA_WIDTH, 512, AXIS tdata width (multiple of 8)
TUSER_WIDTH, 128, AXIS tuser width
NUM_PORTS, 4, MAC/CPU port pairs; port field width PW = 2*NUM_PORTS (≤ 8)
SRC_PORT_POS, 16, LSB of source port field in tuser
DST_PORT_POS, 24, LSB of destination port field in tuser
FIFO_DEPTH_BITS, 2, input FIFO depth = 2**FIFO_DEPTH_BITS (≥ 2)
CNT_WIDTH, 32, counter width including the overflow MSB
DEFAULT_DST, 1, one-hot PW-bit destination used when the source field is zero

Ports:
axis_aclk  in  1  clock
axis_reset  in  1  synchronous reset, active-high
s_axis_tdata/tkeep/tuser/tvalid/tlast  in  DATA_WIDTH/DATA_WIDTH/8/TUSER_WIDTH/1/1  input stream
s_axis_tready  out  1  = !fifo_nearly_full
m_axis_tdata/tkeep/tuser/tvalid/tlast  out  same widths  output stream
m_axis_tready  in  1  downstream ready
mode  in  2  0 = normal pairing, 1 = loopback (dst = src), 2 = drop all, 3 = same as 0
cnt_clear  in  1  synchronous clear of all counters
pkt_in_cnt, pkt_out_cnt, pkt_drop_cnt  out  CNT_WIDTH each  MSB = sticky overflow, low CNT_WIDTH-1 bits = saturating count

Behaviour:
- Reset: state = HEADER, FIFO empty, all counters 0, m_axis_tvalid = 0, s_axis_tready = 1 on the cycle after reset deasserts.
- FIFO:
  - Fall-through; write on s_axis_tvalid & s_axis_tready.
  - nearly_full when occupancy ≥ depth-1.
  - Data path latency 1 cycle (written beat visible at head the next cycle).
- Head decision, evaluated in HEADER when the FIFO is non-empty. src = head tuser[SRC_PORT_POS +: PW].
  - src == 0 → dst = DEFAULT_DST.
  - src not one-hot → DROP.
  - mode 2 → DROP.
  - mode 1 → dst = src.
  - src at even bit 2i (MAC i) → dst bit 2i+1 (CPU i).
  - src at odd bit 2i+1 → dst bit 2i.
- dst and the drop decision are latched on the first beat and applied to every beat of the packet. mode changes mid-packet have no effect until the next HEADER.
- Output tuser = head tuser with [DST_PORT_POS +: PW] replaced by dst; all other bits pass through.
- States:
  - HEADER: forward path: m_axis_tvalid = !empty, rd_en = tvalid & tready. Handshake with tlast → stay HEADER; handshake without tlast → FORWARD. Drop path: m_axis_tvalid = 0, head popped immediately; tlast → stay HEADER (increment drop), else → DROP.
  - FORWARD: tvalid = !empty, rd_en = tvalid & tready. tlast handshake → HEADER.
  - DROP: tvalid = 0, rd_en = !empty, one beat per cycle. Popping tlast → HEADER, pkt_drop_cnt++.
- m_axis_tvalid never depends on m_axis_tready. Output stays stable while tvalid & !tready.
- Counting:
  - pkt_in_cnt increments on an input tlast handshake.
  - pkt_out_cnt increments on an output tlast handshake.
  - pkt_drop_cnt increments as in the DROP path above.
- Counter arithmetic:
  - Count saturates at 2^(CNT_WIDTH-1)-1.
  - An increment while saturated sets the MSB; the MSB is sticky.
  - cnt_clear zeroes count and MSB and wins over a same-cycle increment.
- Simultaneous input and output tlast in one cycle: both counters increment.
- Reset mid-packet: FIFO flushed, partial packets discarded uncounted, state = HEADER.

Optional Feature:
NIC_OPL_IDLE_BYTES_EN
- Defined: adds outputs idle_in_cnt and idle_out_cnt (CNT_WIDTH each, same saturate/sticky/clear rules). On each tlast handshake, add the number of zero tkeep bits on that beat, counted by an adder loop over tkeep. Non-last beats add 0.
- Undefined: the ports and logic are absent.

Test Plan:
- Frame 3 beats, src=0x04 (MAC1), mode 0, tready=1 → 3 output beats, dst field 0x08 on all beats, pkt_in=pkt_out=1.
- Frame src=0x02 (CPU0), then src=0x00 → dst 0x01 for both frames (second via DEFAULT_DST).
- Frame src=0x06 (not one-hot), 4 beats → no m_axis_tvalid, pkt_drop=1. The next valid frame is forwarded unchanged in order.
- mode=1, src=0x10, toggle mode to 0 mid-packet → all beats dst=0x10. Next packet dst=0x20.
- tready held low 10 cycles with a continuous input stream → s_axis_tready drops after 3 accepted beats (depth 4), no beat lost or duplicated, output stable while stalled.
- CNT_WIDTH=4, send 8 single-beat frames → pkt_out_cnt = 0xF (7 saturated, sticky MSB set). Assert cnt_clear in the same cycle as a tlast → counter reads 0. With NIC_OPL_IDLE_BYTES_EN, last-beat tkeep=0x0000_00FF (DATA_WIDTH=512) → idle_out_cnt += 56.
